// File: rtl/des_pkg.sv
// Shared types for the DES byte feeder: FSM encoding, block type, and
// the control bundle that drives a byte shift register.
package des_pkg;
  localparam int BLOCK_BYTES = 8;

  typedef logic [63:0] des_block_t;

  typedef enum logic [1:0] {FILL, START, WAIT_DES, UNLOAD} feeder_state_t;

  typedef struct packed {
    logic       load;
    logic       shift;
    logic [7:0] byte_in;
  } shift_ctl_t;
endpackage

// File: rtl/byte_shift64.sv
// 8-byte shift register: parallel load, or shift one byte in at the LSB end
// while the MSB byte falls off the top (the MSB byte is the outgoing byte).
module byte_shift64
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  shift_ctl_t  ctl,
  input  logic [63:0] load_val,
  output logic [63:0] q
);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)          q <= '0;
    else if (ctl.load)   q <= load_val;
    else if (ctl.shift)  q <= {q[55:0], ctl.byte_in};
  end

endmodule

// File: rtl/des_block_feeder.sv
// Byte-side partner of the iterative DES core: packs rx bytes into data/key
// blocks, runs the start/result handshake and streams the result back out.
module des_block_feeder
  import des_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  input  logic        key_sel,
  input  logic        mode_in,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic        tx_ack,
  output logic [63:0] des_data_in,
  output logic [63:0] des_key,
  output logic        des_rw_mode,
  output logic        des_ready,
  input  logic [63:0] des_data_out,
  input  logic        des_next_data,
  output logic        busy,
  output logic        rx_overrun,
  output logic        timeout_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  feeder_state_t state, state_nxt;
  logic [2:0]    dat_cnt, key_cnt, tx_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          nd_q, nd_rise;
  logic          key_acc, dat_acc, blk_full, tx_take, tmo_hit, res_load;
  shift_ctl_t    dat_ctl, key_ctl, res_ctl;
  des_block_t    res_q;
  logic [55:0]   res_unused;

  assign nd_rise  = des_next_data & ~nd_q;
  // Key bytes are refused only while the core is running rounds.
  assign key_acc  = rx_valid & key_sel & (state != WAIT_DES);
  assign dat_acc  = rx_valid & ~key_sel & (state == FILL);
  assign blk_full = dat_acc & (dat_cnt == 3'(BLOCK_BYTES - 1));
  assign tx_take  = (state == UNLOAD) & tx_ack;
  assign res_load = (state == WAIT_DES) & nd_rise;
  // The des_ready cycle is the first of TIMEOUT_CYCLES; a result on the same edge wins.
  assign tmo_hit  = (state == WAIT_DES) & ~nd_rise & (tmo_cnt == TW'(TIMEOUT_CYCLES - 2));

  always_comb begin
    state_nxt = state;
    des_ready = 1'b0;
    tx_valid  = 1'b0;
    busy      = 1'b1;
    case (state)
      FILL: begin
        busy = 1'b0;
        if (blk_full) state_nxt = START;
      end
      START: begin
        des_ready = 1'b1;
        state_nxt = WAIT_DES;
      end
      WAIT_DES: begin
        if (nd_rise)      state_nxt = UNLOAD;
        else if (tmo_hit) state_nxt = FILL;
      end
      UNLOAD: begin
        tx_valid = 1'b1;
        if (tx_take && tx_cnt == 3'(BLOCK_BYTES - 1)) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= FILL;
      dat_cnt     <= '0;
      key_cnt     <= '0;
      tx_cnt      <= '0;
      tmo_cnt     <= '0;
      nd_q        <= 1'b0;
      des_rw_mode <= 1'b0;
      rx_overrun  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state      <= state_nxt;
      nd_q       <= des_next_data;
      rx_overrun <= rx_valid & ~key_acc & ~dat_acc;
      if (key_acc) key_cnt <= key_cnt + 3'd1;
      if (dat_acc) dat_cnt <= dat_cnt + 3'd1;
      if (tx_take) tx_cnt  <= tx_cnt + 3'd1;
      // Mode is captured with the last data byte so it is valid alongside des_ready.
      if (blk_full) des_rw_mode <= mode_in;
      if (state == START)         tmo_cnt <= '0;
      else if (state == WAIT_DES) tmo_cnt <= tmo_cnt + 1'b1;
      if (tmo_hit)      timeout_err <= 1'b1;
      else if (dat_acc) timeout_err <= 1'b0;
    end
  end

  assign dat_ctl = '{load: 1'b0,     shift: dat_acc, byte_in: rx_byte};
  assign key_ctl = '{load: 1'b0,     shift: key_acc, byte_in: rx_byte};
  assign res_ctl = '{load: res_load, shift: tx_take, byte_in: 8'h00};

  byte_shift64 u_data (
    .clk      (clk),
    .n_rst    (n_rst),
    .ctl      (dat_ctl),
    .load_val ('0),
    .q        (des_data_in)
  );

  byte_shift64 u_key (
    .clk      (clk),
    .n_rst    (n_rst),
    .ctl      (key_ctl),
    .load_val ('0),
    .q        (des_key)
  );

  byte_shift64 u_res (
    .clk      (clk),
    .n_rst    (n_rst),
    .ctl      (res_ctl),
    .load_val (des_data_out),
    .q        (res_q)
  );

  assign {tx_byte, res_unused} = res_q;

endmodule

// File: tb/tb_des_block_feeder.sv
// Directed bench for des_block_feeder with a table-driven stub DES core.
module tb_des_block_feeder;
  localparam int          TMO = 64;
  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] PT  = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT  = 64'h85E813540F0AB405;

  logic        clk = 1'b0, n_rst = 1'b0;
  logic [7:0]  rx_byte = '0, tx_byte;
  logic        rx_valid = 1'b0, key_sel = 1'b0, mode_in = 1'b0, tx_ack = 1'b0;
  logic        tx_valid, des_rw_mode, des_ready, busy, rx_overrun, timeout_err;
  logic [63:0] des_data_in, des_key, des_data_out = '0;
  logic        des_next_data = 1'b0;

  int checks = 0, failures = 0, ovr_cnt = 0, stub_delay = 3;
  bit stub_en = 1'b0;

  des_block_feeder #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .n_rst(n_rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .key_sel(key_sel), .mode_in(mode_in), .tx_byte(tx_byte), .tx_valid(tx_valid),
    .tx_ack(tx_ack), .des_data_in(des_data_in), .des_key(des_key),
    .des_rw_mode(des_rw_mode), .des_ready(des_ready), .des_data_out(des_data_out),
    .des_next_data(des_next_data), .busy(busy), .rx_overrun(rx_overrun),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) if (rx_overrun) ovr_cnt++;

  // Stub core: answers the known KAT pair in both directions, otherwise ~data.
  always begin
    logic [63:0] res;
    @(negedge clk);
    if (stub_en && des_ready) begin
      if (des_key == KEY && des_data_in == PT && !des_rw_mode)     res = CT;
      else if (des_key == KEY && des_data_in == CT && des_rw_mode) res = PT;
      else                                                          res = ~des_data_in;
      repeat (stub_delay) @(negedge clk);
      des_data_out  = res;
      des_next_data = 1'b1;
      @(negedge clk);
      chk("nd_to_tx", tx_valid, 1'b1);
      @(negedge clk);
      des_next_data = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic ks);
    rx_byte = b; key_sel = ks; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; key_sel = 1'b0;
  endtask

  task automatic send_block(input logic [63:0] blk, input logic ks);
    for (int i = 0; i < 8; i++) send_byte(blk[63-8*i -: 8], ks);
  endtask

  task automatic recv_block(input int n, input int hold, output logic [63:0] got, output bit stable);
    int w;
    logic [7:0] b;
    got = '0; stable = 1'b1;
    for (int i = 0; i < n; i++) begin
      w = 0;
      while (!tx_valid && w < 200) begin @(negedge clk); w++; end
      if (!tx_valid) begin chk("tx_wait", tx_valid, 1'b1); return; end
      b = tx_byte;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        if (tx_byte !== b || tx_valid !== 1'b1) stable = 1'b0;
      end
      tx_ack = 1'b1;
      @(negedge clk);
      tx_ack = 1'b0;
      got = {got[55:0], b};
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic [63:0] got, blk;
    bit st, tx_seen;
    int w, ovr0;

    repeat (3) @(negedge clk);
    chk("rst_ctl", {tx_valid, busy, des_ready, rx_overrun, timeout_err, des_rw_mode}, 0);
    chk("rst_din", des_data_in, 0);
    chk("rst_key", des_key, 0);
    chk("rst_txb", tx_byte, 0);
    n_rst = 1'b1;
    @(negedge clk);

    // Known-answer encrypt
    stub_en = 1'b1; stub_delay = 3; mode_in = 1'b0;
    send_block(KEY, 1'b1);
    chk("key_load", des_key, KEY);
    chk("key_idle", busy, 0);
    send_block(PT, 1'b0);
    chk("kat_ready", des_ready, 1);
    chk("kat_din", des_data_in, PT);
    chk("kat_mode", des_rw_mode, 0);
    recv_block(8, 0, got, st);
    chk("kat_ct", got, CT);
    chk("kat_idle", {busy, tx_valid}, 0);

    // Decrypt round trip
    mode_in = 1'b1;
    send_block(CT, 1'b0);
    chk("dec_mode", des_rw_mode, 1);
    recv_block(8, 0, got, st);
    chk("dec_pt", got, PT);

    // Timeout with a silent core
    stub_en = 1'b0; mode_in = 1'b0; tx_seen = 1'b0;
    send_block(64'h1122334455667788, 1'b0);
    chk("tmo_ready", des_ready, 1);
    for (int k = 1; k <= TMO; k++) begin
      @(negedge clk);
      if (tx_valid) tx_seen = 1'b1;
      if (k == TMO - 1) chk("tmo_early", timeout_err, 0);
    end
    chk("tmo_err", timeout_err, 1);
    chk("tmo_fill", busy, 0);
    chk("tmo_notx", tx_seen, 0);

    // Overrun in WAIT_DES (data and key) and in UNLOAD
    stub_en = 1'b1; stub_delay = 6; ovr0 = ovr_cnt; blk = PT;
    send_byte(blk[63:56], 1'b0);
    chk("tmo_clear", timeout_err, 0);
    for (int i = 1; i < 8; i++) send_byte(blk[63-8*i -: 8], 1'b0);
    chk("ovr_ready", des_ready, 1);
    send_byte(8'hAA, 1'b0);
    send_byte(8'h55, 1'b1);
    w = 0;
    while (!tx_valid && w < 100) begin @(negedge clk); w++; end
    send_byte(8'hAA, 1'b0);
    chk("ovr_din", des_data_in, PT);
    chk("ovr_key", des_key, KEY);
    recv_block(8, 0, got, st);
    chk("ovr_ct", got, CT);
    chk("ovr_cnt", ovr_cnt - ovr0, 3);

    // Backpressure
    stub_delay = 1; mode_in = 1'b1;
    send_block(CT, 1'b0);
    recv_block(8, 5, got, st);
    chk("bp_pt", got, PT);
    chk("bp_stable", st, 1);
    chk("bp_idle", busy, 0);

    // Reset in the middle of UNLOAD
    stub_delay = 2; mode_in = 1'b0;
    send_block(PT, 1'b0);
    recv_block(3, 0, got, st);
    chk("rst_part", got, CT >> 40);
    #2 n_rst = 1'b0;
    #1;
    chk("arst_ctl", {tx_valid, busy, des_ready, des_rw_mode}, 0);
    chk("arst_din", des_data_in, 0);
    chk("arst_key", des_key, 0);
    chk("arst_txb", tx_byte, 0);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    send_block(PT, 1'b0);
    chk("post_ready", des_ready, 1);
    recv_block(8, 0, got, st);
    chk("post_blk", got, ~PT);
    chk("post_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
